// File: rtl/imm_extend_unit.sv
// Pipelined immediate extender: one-cycle valid/ready stage producing a DATA_W-bit immediate.
// Define IMM_PREFIX_EN to build the prefix register/FSM that pre-loads upper immediate bits.
module imm_extend_unit #(
  parameter int DATA_W = 19,
  parameter int IN_W   = 15,
  parameter int AR_W   = 5,
  parameter int TD_W   = 10,
  parameter int PFX_W  = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   In,
  input  logic [1:0]        ImmSrc,
  input  logic              sign_en,
  input  logic              is_prefix,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ImmExt,
  output logic              prefix_armed
);

  localparam int XW = DATA_W + IN_W + PFX_W;

  // Keep the low nb bits of v, fill above with bit nb-1 when signed, then truncate.
  function automatic logic [DATA_W-1:0] extend(input logic [XW-1:0] v,
                                               input int unsigned nb,
                                               input logic sgn);
    logic [XW-1:0] mask;
    logic [XW-1:0] top;
    logic [XW-1:0] res;
    mask = ~({XW{1'b1}} << nb);
    res  = v & mask;
    top  = (nb != 0) ? (v >> (nb - 1)) : '0;
    if (sgn && (nb != 0) && top[0]) res = res | ~mask;
    return res[DATA_W-1:0];
  endfunction

  int unsigned       w_fw_p0;
  logic [XW-1:0]     w_field_p0;
  logic [DATA_W-1:0] w_imm_p0;
  logic              w_is_pfx_p0;
  logic              w_accept_p0;
  logic              w_take_p0;
  logic              r_vld_p1;
  logic [DATA_W-1:0] r_imm_p1;

  always_comb begin
    w_fw_p0 = 0;
    case (ImmSrc)
      2'b01:   w_fw_p0 = AR_W;
      2'b10:   w_fw_p0 = TD_W;
      2'b11:   w_fw_p0 = IN_W;
      default: w_fw_p0 = 0;
    endcase
  end

  assign w_field_p0  = XW'(In) >> (IN_W - w_fw_p0);
  assign in_ready    = !r_vld_p1 || out_ready;
  assign w_accept_p0 = in_valid && in_ready && !flush;
  assign w_take_p0   = w_accept_p0 && !w_is_pfx_p0;

`ifdef IMM_PREFIX_EN
  typedef enum logic {S_IDLE, S_ARMED} state_t;
  state_t             r_state;
  state_t             w_state_nxt;
  logic [PFX_W-1:0]   r_prefix;

  assign w_is_pfx_p0  = is_prefix;
  assign prefix_armed = (r_state == S_ARMED);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_prefix <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept_p0 && is_prefix) r_prefix <= In[IN_W-1 -: PFX_W];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush)            w_state_nxt = S_IDLE;
    else if (w_accept_p0) w_state_nxt = is_prefix ? S_ARMED : S_IDLE;
  end

  always_comb begin
    w_imm_p0 = '0;
    if (ImmSrc == 2'b00)
      w_imm_p0 = '0;
    else if (r_state == S_ARMED)
      w_imm_p0 = extend((XW'(r_prefix) << w_fw_p0) | w_field_p0,
                        w_fw_p0 + PFX_W, sign_en);
    else
      w_imm_p0 = extend(w_field_p0, w_fw_p0, sign_en);
  end
`else
  logic w_unused_is_prefix;

  assign w_unused_is_prefix = is_prefix;
  assign w_is_pfx_p0        = 1'b0;
  assign prefix_armed       = 1'b0;
  assign w_imm_p0           = extend(w_field_p0, w_fw_p0, sign_en);
`endif

  // Stage p0 -> p1: output register, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
      r_imm_p1 <= '0;
    end else if (flush) begin
      r_vld_p1 <= 1'b0;
    end else if (w_take_p0) begin
      r_vld_p1 <= 1'b1;
      r_imm_p1 <= w_imm_p0;
    end else if (out_ready) begin
      r_vld_p1 <= 1'b0;
    end
  end

  assign out_valid = r_vld_p1;
  assign ImmExt    = r_imm_p1;

endmodule
